// File: rtl/nrx_pkg.sv
// nrx_pkg: constants and types shared by the New Rally-X ROM download transmitter.
//   Region ROMAD bases and sizes, the region index enum and the loader FSM encoding.
package nrx_pkg;

   localparam logic [15:0] CHR_BASE  = 16'h8000;
   localparam logic [15:0] DOT_BASE  = 16'h9000;
   localparam logic [15:0] CLUT_BASE = 16'h9200;
   localparam logic [15:0] PAL_BASE  = 16'h9300;

   localparam int unsigned CHR_SIZE     = 4096;
   localparam int unsigned DOT_SIZE     = 256;
   localparam int unsigned CLUT_SIZE    = 256;
   localparam int unsigned PAL_SIZE     = 32;
   localparam int unsigned CPU_SIZE_DEF = 16384;

   // Value doubles as the bit position in REGION_DONE.
   typedef enum logic [2:0] {
      CPU  = 3'd0,
      CHR  = 3'd1,
      DOT  = 3'd2,
      CLUT = 3'd3,
      PAL  = 3'd4
   } region_e;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_WRITE = 2'd1;
   localparam state_t S_GAP   = 2'd2;
   localparam state_t S_FULL  = 2'd3;

endpackage

// File: rtl/nrx_rom_addr_map.sv
// nrx_rom_addr_map: combinational map from a linear download-file offset to the sparse
// ROMAD space.
//   addr     : linear byte offset in the download file
//   data     : raw byte
//   in_range : offset falls inside one of the five regions
//   region   : region index (meaningful only when in_range)
//   romad    : mapped ROM address
//   romdt    : data to write (clut entries keep only the low nibble)
module nrx_rom_addr_map
   import nrx_pkg::*;
#(
   parameter int unsigned CPU_SIZE = CPU_SIZE_DEF
) (
   input  logic [16:0] addr,
   input  logic [7:0]  data,
   output logic        in_range,
   output region_e     region,
   output logic [15:0] romad,
   output logic [7:0]  romdt
);

   // Offset relative to the end of the CPU image; only used above CPU_SIZE.
   logic [16:0] rel;

   always_comb begin
      rel      = addr - 17'(CPU_SIZE);
      in_range = 1'b0;
      region   = CPU;
      romad    = addr[15:0];
      romdt    = data;
      if (32'(addr) < CPU_SIZE) begin
         in_range = 1'b1;
      end else if (rel < 17'(CHR_SIZE)) begin
         in_range = 1'b1;
         region   = CHR;
         romad    = CHR_BASE | {4'h0, rel[11:0]};
      end else if (rel < 17'(CHR_SIZE + DOT_SIZE)) begin
         in_range = 1'b1;
         region   = DOT;
         romad    = DOT_BASE | {8'h00, rel[7:0]};
      end else if (rel < 17'(CHR_SIZE + DOT_SIZE + CLUT_SIZE)) begin
         in_range = 1'b1;
         region   = CLUT;
         romad    = CLUT_BASE | {8'h00, rel[7:0]};
         romdt    = {4'h0, data[3:0]};
      end else if (rel < 17'(CHR_SIZE + DOT_SIZE + CLUT_SIZE + PAL_SIZE)) begin
         in_range = 1'b1;
         region   = PAL;
         romad    = PAL_BASE | {11'h000, rel[4:0]};
      end
   end

endmodule

// File: rtl/nrx_rom_loader.sv
// nrx_rom_loader: transmitter side of the ROMCL/ROMAD/ROMDT/ROMEN download port.
// Takes a linear byte stream over valid/ready, remaps it into the sparse ROM map, spaces
// the ROMEN strobes, tracks per-region fill, keeps an additive checksum and flags errors.
//   ROMCL, RESET_N       : clock, asynchronous active-low reset
//   IN_VALID/IN_READY    : byte stream handshake; IN_ADDR offset, IN_DATA byte
//   ROMAD, ROMDT, ROMEN  : ROM write port (ROMEN is a one-cycle strobe)
//   REGION_DONE, DONE    : per-region full flags, all-full flag
//   ERR                  : sticky write-to-full-region or non-ascending offset
//   CHKSUM               : 16-bit wrapping sum of every written byte
module nrx_rom_loader
   import nrx_pkg::*;
#(
   parameter int unsigned GAP      = 2,
   parameter int unsigned CPU_SIZE = CPU_SIZE_DEF
) (
   input  logic        ROMCL,
   input  logic        RESET_N,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [16:0] IN_ADDR,
   input  logic [7:0]  IN_DATA,
   output logic [15:0] ROMAD,
   output logic [7:0]  ROMDT,
   output logic        ROMEN,
   output logic [4:0]  REGION_DONE,
   output logic        DONE,
   output logic        ERR,
   output logic [15:0] CHKSUM
);

   logic        map_in_range;
   region_e     map_rgn;
   logic [15:0] map_ad;
   logic [7:0]  map_dt;

   nrx_rom_addr_map #(
      .CPU_SIZE(CPU_SIZE)
   ) u_map (
      .addr    (IN_ADDR),
      .data    (IN_DATA),
      .in_range(map_in_range),
      .region  (map_rgn),
      .romad   (map_ad),
      .romdt   (map_dt)
   );

   state_t      state_q, state_d;
   logic [2:0]  gap_q, gap_d;
   logic [15:0] ad_q, ad_d;
   logic [7:0]  dt_q, dt_d;
   region_e     rgn_q, rgn_d;
   logic [14:0] cnt_cpu_q, cnt_cpu_d;
   logic [12:0] cnt_chr_q, cnt_chr_d;
   logic [8:0]  cnt_dot_q, cnt_dot_d;
   logic [8:0]  cnt_clut_q, cnt_clut_d;
   logic [5:0]  cnt_pal_q, cnt_pal_d;
   logic [4:0]  rdone_q, rdone_d;
   logic        err_q, err_d;
   logic [15:0] chk_q, chk_d;
   logic [16:0] last_q, last_d;
   logic        have_last_q, have_last_d;
   logic        hs;
   logic        out_of_order;

   // Gating with RESET_N keeps the stream stalled while reset is held.
   assign IN_READY = RESET_N & ((state_q == S_IDLE) | (state_q == S_FULL));
   assign hs       = IN_VALID & IN_READY;
   // The first byte after reset has no predecessor to compare against.
   assign out_of_order = have_last_q & (IN_ADDR <= last_q);

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      ad_d        = ad_q;
      dt_d        = dt_q;
      rgn_d       = rgn_q;
      cnt_cpu_d   = cnt_cpu_q;
      cnt_chr_d   = cnt_chr_q;
      cnt_dot_d   = cnt_dot_q;
      cnt_clut_d  = cnt_clut_q;
      cnt_pal_d   = cnt_pal_q;
      rdone_d     = rdone_q;
      err_d       = err_q;
      chk_d       = chk_q;
      last_d      = last_q;
      have_last_d = have_last_q;
      unique case (state_q)
         S_IDLE: begin
            if (hs && map_in_range) begin
               last_d      = IN_ADDR;
               have_last_d = 1'b1;
               if (out_of_order || rdone_q[map_rgn]) err_d = 1'b1;
               // Out-of-order bytes are still written; only full regions are dropped.
               if (!rdone_q[map_rgn]) begin
                  ad_d    = map_ad;
                  dt_d    = map_dt;
                  rgn_d   = map_rgn;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            chk_d = chk_q + {8'h00, dt_q};
            unique case (rgn_q)
               CPU: begin
                  cnt_cpu_d  = cnt_cpu_q + 15'd1;
                  rdone_d[0] = (32'(cnt_cpu_d) == CPU_SIZE);
               end
               CHR: begin
                  cnt_chr_d  = cnt_chr_q + 13'd1;
                  rdone_d[1] = (32'(cnt_chr_d) == CHR_SIZE);
               end
               DOT: begin
                  cnt_dot_d  = cnt_dot_q + 9'd1;
                  rdone_d[2] = (32'(cnt_dot_d) == DOT_SIZE);
               end
               CLUT: begin
                  cnt_clut_d = cnt_clut_q + 9'd1;
                  rdone_d[3] = (32'(cnt_clut_d) == CLUT_SIZE);
               end
               PAL: begin
                  cnt_pal_d  = cnt_pal_q + 6'd1;
                  rdone_d[4] = (32'(cnt_pal_d) == PAL_SIZE);
               end
               default: ;
            endcase
            if (GAP != 0) begin
               gap_d   = 3'(GAP);
               state_d = S_GAP;
            end else begin
               state_d = (&rdone_d) ? S_FULL : S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_q <= 3'd1) state_d = (&rdone_q) ? S_FULL : S_IDLE;
            else               gap_d   = gap_q - 3'd1;
         end
         S_FULL: begin
            if (hs && map_in_range) err_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ROMCL or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         gap_q       <= 3'd0;
         ad_q        <= 16'h0000;
         dt_q        <= 8'h00;
         rgn_q       <= CPU;
         cnt_cpu_q   <= '0;
         cnt_chr_q   <= '0;
         cnt_dot_q   <= '0;
         cnt_clut_q  <= '0;
         cnt_pal_q   <= '0;
         rdone_q     <= 5'b00000;
         err_q       <= 1'b0;
         chk_q       <= 16'h0000;
         last_q      <= '0;
         have_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         ad_q        <= ad_d;
         dt_q        <= dt_d;
         rgn_q       <= rgn_d;
         cnt_cpu_q   <= cnt_cpu_d;
         cnt_chr_q   <= cnt_chr_d;
         cnt_dot_q   <= cnt_dot_d;
         cnt_clut_q  <= cnt_clut_d;
         cnt_pal_q   <= cnt_pal_d;
         rdone_q     <= rdone_d;
         err_q       <= err_d;
         chk_q       <= chk_d;
         last_q      <= last_d;
         have_last_q <= have_last_d;
      end
   end

   // Decoded straight from the state flop so reset kills the strobe immediately.
   assign ROMEN       = (state_q == S_WRITE);
   assign ROMAD       = ad_q;
   assign ROMDT       = dt_q;
   assign REGION_DONE = rdone_q;
   assign DONE        = (state_q == S_FULL);
   assign ERR         = err_q;
   assign CHKSUM      = chk_q;

endmodule

// File: tb/tb_nrx_rom_loader.sv
// Scoreboard bench: drivers push expected ROM writes computed from a table-driven region
// model; independent monitors pop and compare whenever ROMEN strobes.
module tb_nrx_rom_loader;

   logic        ROMCL, RESET_N;
   logic        in_valid, in_ready, romen, done, err;
   logic [16:0] in_addr;
   logic [7:0]  in_data, romdt;
   logic [15:0] romad, chksum;
   logic [4:0]  region_done;
   logic        v3, ready3, romen3, done3, err3;
   logic [16:0] a3;
   logic [7:0]  d3, romdt3;
   logic [15:0] romad3, chksum3;
   logic [4:0]  region_done3;

   nrx_rom_loader #(.GAP(2), .CPU_SIZE(16384)) dut (
      .ROMCL(ROMCL), .RESET_N(RESET_N), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_ADDR(in_addr), .IN_DATA(in_data), .ROMAD(romad), .ROMDT(romdt), .ROMEN(romen),
      .REGION_DONE(region_done), .DONE(done), .ERR(err), .CHKSUM(chksum)
   );

   nrx_rom_loader #(.GAP(3), .CPU_SIZE(16384)) dut3 (
      .ROMCL(ROMCL), .RESET_N(RESET_N), .IN_VALID(v3), .IN_READY(ready3),
      .IN_ADDR(a3), .IN_DATA(d3), .ROMAD(romad3), .ROMDT(romdt3), .ROMEN(romen3),
      .REGION_DONE(region_done3), .DONE(done3), .ERR(err3), .CHKSUM(chksum3)
   );

   typedef struct {
      int          cyc;
      logic [15:0] ad;
      logic [7:0]  dt;
   } exp_t;

   exp_t q[$];
   exp_t q3[$];
   int   n_checks = 0;
   int   n_errs = 0;
   int   cyc = 0;
   int   romen_cnt = 0;
   int   last_en = -1;
   int   bad_spacing = 0;
   bit   stream_on = 0;
   int   prev_low3 = 0;

   // Reference map: region r covers offsets [lo, lo+size) and lands at base + (a - lo).
   int lo_tab[5]   = '{0, 'h4000, 'h5000, 'h5100, 'h5200};
   int sz_tab[5]   = '{16384, 4096, 256, 256, 32};
   int base_tab[5] = '{0, 'h8000, 'h9000, 'h9200, 'h9300};

   int          m_cnt[5];
   logic [15:0] m_chk;
   bit          m_err;
   bit          m_have_last;
   int          m_last;

   initial begin
      ROMCL = 1'b0;
      forever #5 ROMCL = ~ROMCL;
   end

   always @(posedge ROMCL) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic int find_region(input int a);
      for (int r = 0; r < 5; r++)
         if (a >= lo_tab[r] && a < lo_tab[r] + sz_tab[r]) return r;
      return -1;
   endfunction

   function automatic logic [4:0] m_rdone();
      logic [4:0] v;
      for (int r = 0; r < 5; r++) v[r] = (m_cnt[r] == sz_tab[r]);
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 5; r++) m_cnt[r] = 0;
      m_chk       = 16'h0000;
      m_err       = 1'b0;
      m_have_last = 1'b0;
      m_last      = 0;
      q.delete();
      q3.delete();
      prev_low3 = 0;
   endtask

   task automatic accept(input int a, input logic [7:0] d, input int c);
      int          r;
      logic [7:0]  md;
      exp_t        e;
      r = find_region(a);
      if (r < 0) return;
      if (m_rdone() == 5'b11111) begin
         m_err = 1'b1;
         return;
      end
      if (m_have_last && a <= m_last) m_err = 1'b1;
      m_last      = a;
      m_have_last = 1'b1;
      if (m_cnt[r] == sz_tab[r]) begin
         m_err = 1'b1;
         return;
      end
      md = (r == 3) ? (d & 8'h0f) : d;
      m_cnt[r]++;
      m_chk = m_chk + {8'h00, md};
      e.cyc = c + 1;
      e.ad  = 16'(base_tab[r] + (a - lo_tab[r]));
      e.dt  = md;
      q.push_back(e);
   endtask

   task automatic send(input int a, input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_addr  = 17'(a);
      in_data  = d;
      @(negedge ROMCL);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge ROMCL);
      end
      if (!in_ready) check("handshake_timeout", {31'b0, in_ready}, 1);
      else accept(a, d, cyc);
      @(posedge ROMCL);
      #1;
   endtask

   // GAP=3 instance: counts READY-low cycles left over from the previous byte.
   task automatic send3(input int a, input logic [7:0] d);
      int   n = 0;
      int   r;
      exp_t e;
      v3 = 1'b1;
      a3 = 17'(a);
      d3 = d;
      @(negedge ROMCL);
      while (!ready3 && n < 50) begin
         n++;
         @(negedge ROMCL);
      end
      check("ready_low_cycles", n, prev_low3);
      r = find_region(a);
      if (r >= 0) begin
         e.cyc = 0;
         e.ad  = 16'(base_tab[r] + (a - lo_tab[r]));
         e.dt  = (r == 3) ? (d & 8'h0f) : d;
         q3.push_back(e);
         prev_low3 = 4;
      end else begin
         prev_low3 = 0;
      end
      @(posedge ROMCL);
      #1;
   endtask

   task automatic settle(input int n);
      in_valid = 1'b0;
      v3       = 1'b0;
      repeat (n) @(posedge ROMCL);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_chksum"}, chksum, m_chk);
      check({tag, "_err"}, err, m_err);
      check({tag, "_region_done"}, region_done, m_rdone());
      check({tag, "_done"}, done, (m_rdone() == 5'b11111));
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      in_valid = 1'b0;
      v3       = 1'b0;
      model_reset();
      repeat (3) @(negedge ROMCL);
      check("rst_romad", romad, 0);
      check("rst_romdt", romdt, 0);
      check("rst_romen", romen, 0);
      check("rst_ready", in_ready, 0);
      check("rst_region_done", region_done, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_chksum", chksum, 0);
      RESET_N = 1'b1;
      #1 check("ready_after_release", in_ready, 1);
      @(posedge ROMCL);
      #1;
   endtask

   always @(negedge ROMCL) begin
      exp_t e;
      if (RESET_N && romen) begin
         romen_cnt++;
         if (stream_on && last_en >= 0 && (cyc - last_en) != 4) bad_spacing++;
         last_en = cyc;
         if (q.size() == 0) begin
            check("unexpected_romen", {31'b0, romen}, 0);
         end else begin
            e = q.pop_front();
            check("romad", romad, e.ad);
            check("romdt", romdt, e.dt);
            check("romen_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge ROMCL) begin
      exp_t e;
      if (RESET_N && romen3) begin
         if (q3.size() == 0) begin
            check("unexpected_romen3", {31'b0, romen3}, 0);
         end else begin
            e = q3.pop_front();
            check("romad3", romad3, e.ad);
            check("romdt3", romdt3, e.dt);
         end
      end
   end

   initial begin
      logic [15:0] snap;
      int          a;
      int          cnt_snap;
      RESET_N  = 1'b0;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      v3       = 1'b0;
      a3       = '0;
      d3       = '0;
      do_reset();

      // Backpressure on the GAP=3 instance with IN_VALID held high.
      a = int'($urandom_range(0, 255));
      for (int i = 0; i < 24; i++) begin
         send3(a, 8'($urandom));
         a = a + 1 + int'($urandom_range(0, 800));
      end
      send3('h1ffff, 8'($urandom));
      send3('h1fffe, 8'($urandom));
      settle(4);
      check("q3_drained", q3.size(), 0);

      // Single bytes on the GAP=2 instance.
      send('h4123, 8'hA5);
      send('h5110, 8'hF7);
      send('h5205, 8'($urandom));
      settle(6);
      snap = chksum;
      send('h6000, 8'($urandom));
      settle(6);
      check("oor_chksum_unchanged", chksum, snap);
      check("oor_err", err, 0);
      check_state("single");

      // Descending offsets: both written, ERR raised.
      do_reset();
      send('h4010, 8'($urandom));
      send('h4005, 8'($urandom));
      settle(6);
      check("order_err", err, 1);
      check_state("order");

      // Reset asserted while ROMEN is high.
      do_reset();
      send('h0123, 8'($urandom));
      check("romen_before_reset", romen, 1);
      #2 RESET_N = 1'b0;
      #1 check("romen_async_drop", romen, 0);
      do_reset();

      // Full ascending download.
      romen_cnt = 0;
      last_en   = -1;
      stream_on = 1'b1;
      for (int i = 0; i <= 'h521f; i++) send(i, 8'($urandom));
      settle(10);
      stream_on = 1'b0;
      check("pulse_count", romen_cnt, 21024);
      check("pulse_spacing_errors", bad_spacing, 0);
      check("full_region_done", region_done, 5'b11111);
      check("full_done", done, 1);
      check("full_err", err, 0);
      check("queue_drained", q.size(), 0);
      check_state("full");

      // In-range byte after DONE.
      snap     = chksum;
      cnt_snap = romen_cnt;
      send('h5000, 8'($urandom));
      settle(6);
      check("post_done_err", err, 1);
      check("post_done_done", done, 1);
      check("post_done_chksum", chksum, snap);
      check("post_done_no_romen", romen_cnt, cnt_snap);
      check_state("post_done");

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
